// File: rtl/serial_pkg.sv
// Shared types and constants for the serializer and the detector-side blocks.
// No logic: typedefs and localparams only.
// Imported by word_serializer and word_prefetch_reg.
package serial_pkg;

    // Default serial word length in bits
    localparam int DEFAULT_WIDTH = 8;

    // Serializer control states: IDLE = nothing shifting, SHIFT = word on the wire
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/word_prefetch_reg.sv
// One-entry word holding register with valid/ready on both sides.
// Latency: one cycle from input transfer to out_valid.
// Backpressure: in_ready is low while the entry is full; the entry drains when out_ready is high.
module word_prefetch_reg
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             full;
    logic [WIDTH-1:0] data;

    assign in_ready  = !full;
    assign out_valid = full;
    assign out_data  = data;

    // Fill when empty and offered; empty when the consumer takes the word.
    // Fill and drain never coincide because in_ready requires the entry empty.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            full <= 1'b0;
            data <= '0;
        end else if (in_valid && in_ready) begin
            full <= 1'b1;
            data <= in_data;
        end else if (out_valid && out_ready) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial word converter, MSB first, with first/last bit markers.
// Latency: MSB of a word accepted at edge k is on dout in the cycle after edge k.
// Backpressure: din_ready is high in IDLE and on the last bit (zero-bubble reload);
//   with WORD_SERIALIZER_PREFETCH_EN defined it is high in SHIFT while the one-word prefetch is empty.
module word_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             dout_first,
    output logic             dout_last
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [CW-1:0]    cnt_inc;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic             dout_nxt;
    logic             dout_valid_nxt;
    logic             dout_first_nxt;
    logic             dout_last_nxt;

    // at_last: the LSB of the current word is on dout this cycle
    logic             at_last;
    // load: a new word enters the shift register at the coming edge
    logic             load;
    logic [WIDTH-1:0] load_word;

    assign at_last = (state == SHIFT) && (cnt == LAST_CNT);
    assign cnt_inc = cnt + CW'(1);

`ifdef WORD_SERIALIZER_PREFETCH_EN
    logic             pf_in_valid;
    logic             pf_in_ready;
    logic             pf_out_valid;
    logic             pf_out_ready;
    logic [WIDTH-1:0] pf_out_data;

    // Ready depends on state and prefetch occupancy only; forced low while in reset
    assign din_ready    = resetn && ((state == IDLE) || pf_in_ready);
    // Mid-word transfers park in the prefetch; a last-bit transfer with an empty
    // prefetch bypasses it and loads the shift register directly
    assign pf_in_valid  = din_valid && (state == SHIFT) && !at_last;
    assign pf_out_ready = at_last;
    assign load         = ((state == IDLE) && din_valid && din_ready) ||
                          (at_last && (pf_out_valid || (din_valid && din_ready)));
    assign load_word    = pf_out_valid ? pf_out_data : din;

    word_prefetch_reg #(
        .WIDTH (WIDTH)
    ) u_prefetch (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (pf_in_valid),
        .in_ready  (pf_in_ready),
        .in_data   (din),
        .out_valid (pf_out_valid),
        .out_ready (pf_out_ready),
        .out_data  (pf_out_data)
    );
`else
    // Ready depends on state only; forced low while in reset
    assign din_ready = resetn && ((state == IDLE) || at_last);
    assign load      = din_valid && din_ready;
    assign load_word = din;
`endif

    // State register plus registered datapath and outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cnt        <= '0;
            sreg       <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            dout_first <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sreg       <= sreg_nxt;
            dout       <= dout_nxt;
            dout_valid <= dout_valid_nxt;
            dout_first <= dout_first_nxt;
            dout_last  <= dout_last_nxt;
        end
    end

    // Next-state: enter SHIFT on a load, leave it after the last bit if nothing reloads
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = SHIFT;
            SHIFT:   if (at_last && !load) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath/output next values; sreg[WIDTH-1] always mirrors the bit on dout
    always_comb begin
        cnt_nxt        = cnt;
        sreg_nxt       = sreg;
        dout_nxt       = 1'b0;
        dout_valid_nxt = 1'b0;
        dout_first_nxt = 1'b0;
        dout_last_nxt  = 1'b0;
        if (load) begin
            sreg_nxt       = load_word;
            cnt_nxt        = '0;
            dout_nxt       = load_word[WIDTH-1];
            dout_valid_nxt = 1'b1;
            dout_first_nxt = 1'b1;
        end else if ((state == SHIFT) && !at_last) begin
            sreg_nxt       = {sreg[WIDTH-2:0], 1'b0};
            cnt_nxt        = cnt_inc;
            dout_nxt       = sreg[WIDTH-2];
            dout_valid_nxt = 1'b1;
            dout_last_nxt  = (cnt_inc == LAST_CNT);
        end else if (at_last) begin
            sreg_nxt = '0;
            cnt_nxt  = '0;
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer (WIDTH=8) with a cycle-stamped bit scoreboard.
// Words are pushed as expected bits when a transfer is committed; a negedge monitor pops and compares.
// Prefetch-specific steps are selected by WORD_SERIALIZER_PREFETCH_EN.
module tb_word_serializer;
    import serial_pkg::*;

    localparam int W = 8;

    typedef struct {
        int   cyc;
        logic b;
        logic f;
        logic l;
    } exp_t;

    logic         clk = 1'b0;
    logic         resetn;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         dout;
    logic         dout_valid;
    logic         dout_first;
    logic         dout_last;

    int   vectors = 0;
    int   fails = 0;
    int   ecount;
    int   busy_until = -1;
    exp_t sb[$];
    exp_t mon_e;
    logic mon_due;

    word_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_first (dout_first),
        .dout_last  (dout_last)
    );

    always #5 clk = ~clk;

    // Cycle n is the period after edge n-1; ecount equals the current cycle at negedge
    always @(posedge clk or negedge resetn) begin
        if (!resetn) ecount <= 0;
        else         ecount <= ecount + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every cycle either a due bit appears exactly, or the line is all zero
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            mon_due = (sb.size() > 0) && (sb[0].cyc <= ecount);
            chk("dout_valid", dout_valid, mon_due);
            if (mon_due) begin
                mon_e = sb.pop_front();
                chk("bit_cycle", ecount, mon_e.cyc);
                chk("dout", dout, mon_e.b);
                chk("dout_first", dout_first, mon_e.f);
                chk("dout_last", dout_last, mon_e.l);
            end else begin
                chk("idle_dout", dout, 1'b0);
                chk("idle_first", dout_first, 1'b0);
                chk("idle_last", dout_last, 1'b0);
            end
        end
    end

    // Offer a word (called just after a negedge); waits for ready, then records its expected bits.
    // Returns just after the following negedge with din_valid still asserted.
    task automatic send(input logic [W-1:0] w);
        int   guard;
        int   start;
        exp_t x;
        guard     = 0;
        din       = w;
        din_valid = 1'b1;
        while (!din_ready && guard < 100) begin
            @(negedge clk); #1;
            guard++;
        end
        if (guard >= 100) begin
            chk("send_timeout", guard, 0);
        end else begin
            start = (ecount + 1 > busy_until) ? ecount + 1 : busy_until + 1;
            for (int i = 0; i < W; i++) begin
                x.cyc = start + i;
                x.b   = w[W-1-i];
                x.f   = (i == 0);
                x.l   = (i == W - 1);
                sb.push_back(x);
            end
            busy_until = start + W - 1;
        end
        @(negedge clk); #1;
    endtask

    // Wait until all expected bits are out, then confirm the line goes idle next cycle
    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 300) begin
            @(negedge clk); #1;
            guard++;
        end
        if (guard >= 300) chk("drain_timeout", guard, 0);
        @(negedge clk); #1;
        chk("post_word_valid", dout_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rw;
        resetn    = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_dout", dout, 1'b0);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_first", dout_first, 1'b0);
        chk("rst_last", dout_last, 1'b0);
        chk("rst_ready", din_ready, 1'b0);
        resetn = 1'b1;
        #1;
        chk("rel_ready", din_ready, 1'b1);

        // Single word 0x96 at edge 0: bits 1,0,0,1,0,1,1,0 on cycles 1..8
        send(8'h96);
        din_valid = 1'b0;
        drain();

        // Back-to-back 0x03 then 0xFF: 16 contiguous bits
        send(8'h03);
        send(8'hFF);
        din_valid = 1'b0;
        drain();

`ifdef WORD_SERIALIZER_PREFETCH_EN
        // 0x96 then 0x0F offered two edges later lands in the prefetch
        send(8'h96);
        din_valid = 1'b0;
        @(negedge clk); #1;
        chk("pf_ready_c2", din_ready, 1'b1);
        send(8'h0F);
        din = 8'hA5;
        for (int c = 3; c <= 8; c++) begin
            chk("pf_ready_full", din_ready, 1'b0);
            @(negedge clk); #1;
        end
        din_valid = 1'b0;
        drain();
`else
        // din_valid held: ready low on cycles 1..7, high on 8; din churn is ignored
        send(8'h96);
        for (int c = 1; c <= 7; c++) begin
            chk("hold_ready_low", din_ready, 1'b0);
            din = W'($urandom_range(0, 255));
            @(negedge clk); #1;
        end
        chk("hold_ready_last", din_ready, 1'b1);
        send(8'hC3);
        din_valid = 1'b0;
        drain();
`endif

        // Reset mid-word aborts 0x96; a fresh 0x03 follows cleanly
        send(8'h96);
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        resetn = 1'b0;
        #1;
        sb.delete();
        busy_until = -1;
        chk("abort_dout", dout, 1'b0);
        chk("abort_valid", dout_valid, 1'b0);
        chk("abort_first", dout_first, 1'b0);
        chk("abort_last", dout_last, 1'b0);
        chk("abort_ready", din_ready, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        resetn = 1'b1;
        #1;
        send(8'h03);
        din_valid = 1'b0;
        drain();

        // A run of random back-to-back words
        for (int i = 0; i < 6; i++) begin
            rw = W'($urandom_range(0, 255));
            send(rw);
        end
        din_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 Parameter: WIDTH, default 8, word length in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 din  input  WIDTH  parallel word to serialize.
REQ-005 din_valid  input  1  din holds a word.
REQ-006 din_ready  output  1  block accepts din this cycle; transfer when din_valid && din_ready at a rising edge.
REQ-007 dout  output  1  serial bit, MSB first; feeds the serial divisible-by-3 detector's din.
REQ-008 dout_valid  output  1  dout carries a word bit this cycle.
REQ-009 dout_first  output  1  dout is the MSB of a word.
REQ-010 dout_last  output  1  dout is the LSB of a word.

Function
REQ-011 States: IDLE (no word shifting) and SHIFT (word in shift register); a bit counter runs 0..WIDTH-1.
REQ-012 IDLE -> SHIFT on a transfer; the accepted word loads the shift register, counter := 0.
REQ-013 In SHIFT, the counter increments each cycle; at counter == WIDTH-1, the next state is SHIFT with a new word if one is available, else IDLE.
REQ-014 All outputs except din_ready are registered; the MSB of a word accepted at edge k is on dout in the cycle after edge k (latency 1).
REQ-015 A word occupies exactly WIDTH consecutive dout_valid cycles, with no gaps inside a word.
REQ-016 dout_first is high only on the bit with counter == 0; dout_last is high only on counter == WIDTH-1; both are high only with dout_valid.
REQ-017 When dout_valid is 0, dout, dout_first and dout_last are 0.
REQ-018 din_ready is combinational from state only, never from din_valid. It is 1 in IDLE, and 1 in SHIFT with counter == WIDTH-1 (base build).
REQ-019 A transfer during the last-bit cycle makes the next word's MSB follow the LSB on the very next cycle (zero bubble).
REQ-020 Upstream holds din and din_valid stable until the transfer; din is ignored when din_valid is 0.
REQ-021 No output stall exists; the downstream stage is always ready.

Reset
REQ-022 While resetn is 0: state IDLE, counter 0, shift register 0, dout, dout_valid, dout_first and dout_last all 0, din_ready 0.
REQ-023 Reset asserted mid-word aborts the word immediately; a partially sent or buffered word is discarded and never replayed.
REQ-024 On the first edge after resetn rises, din_ready is 1.

Configuration
REQ-025 Macro WORD_SERIALIZER_PREFETCH_EN adds a one-word prefetch register.
- Defined: din_ready = !prefetch_full in SHIFT, and 1 in IDLE. A transfer in SHIFT fills the prefetch. At the last bit the prefetch, else a same-cycle transfer, loads the shift register. Prefetch clears on reset.
- Undefined: REQ-018 applies exactly, with no prefetch storage.
- The serial output timing for a given accepted-word sequence is identical in both builds.

Structure
REQ-026 Package serial_pkg holds the state enum typedef (IDLE, SHIFT) and the default WIDTH constant, shared with the detector-side blocks.
REQ-027 The prefetch register is one sub-module, word_prefetch_reg (valid/ready in and out, one entry). It is instantiated only under WORD_SERIALIZER_PREFETCH_EN.

Verification (WIDTH=8)
REQ-028 Reset, then 0x96 offered at edge 0 -> dout = 1,0,0,1,0,1,1,0 on cycles 1..8; dout_first at cycle 1, dout_last at cycle 8; dout_valid 0 at cycle 9.
REQ-029 0x03 then 0xFF offered back-to-back -> 16 contiguous valid bits 00000011 11111111, with dout_first at cycles 1 and 9.
REQ-030 Base build, din_valid held high from cycle 0 -> din_ready is 0 on cycles 1..7 and 1 on cycle 8; din changes while ready is 0 do not corrupt the word in flight.
REQ-031 Prefetch build: 0x96 at edge 0, 0x0F offered at edge 2 -> accepted at edge 2; din_ready 0 from cycle 3 through the last-bit cycle; 0x0F MSB at cycle 9.
REQ-032 resetn pulsed low at cycle 4 of 0x96 -> all outputs 0 immediately; after release, a fresh 0x03 serializes cleanly with no residue of 0x96.
